// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
package uart_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = DATA_BITS * BYTES_PER_WORD;

endpackage

// File: rtl/uart_rx_word_fifo.sv
// Synchronous word FIFO with extra-MSB pointers; a push into a full FIFO
// without a simultaneous pop is dropped and flagged on drop_o.
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot on the same edge, so a full FIFO can still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    // Head reads as zero when empty so the output is clean out of reset.
    assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs every four accepted bytes little-endian
// into a 32-bit word and queues the words for a valid/ready consumer.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 5,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxd,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        rx_busy,
    output logic        overrun,
    output logic        frame_err
);

    import uart_pkg::*;

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam int             AWB  = (BYTES_PER_WORD - 1) * DATA_BITS;

    logic                 sync1_q, sync2_q, rxd_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 rx_byte_valid_q, rx_byte_valid_d;
    logic [1:0]           bidx_q, bidx_d;
    logic [AWB-1:0]       asm_q, asm_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 push;
    logic [WORD_W-1:0]    push_word;
    logic                 fifo_empty, fifo_drop, fifo_pop;
    logic                 fifo_full_unused;  // drop already encodes full-without-pop

    assign rxd_s = sync2_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_d           = bit_q;
        shift_d         = shift_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        bidx_d          = bidx_q;
        asm_d           = asm_q;
        frame_err_d     = frame_err_q;
        overrun_d       = overrun_q | fifo_drop;
        push            = 1'b0;
        push_word       = {shift_q, asm_q};

        case (state_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    if (rxd_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = '0;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    shift_d[bit_q] = rxd_s;
                    cnt_d          = '0;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    // Back to idle right away so an early next start bit is caught.
                    state_d = RX_IDLE;
                    if (rxd_s) begin
                        rx_byte_d       = shift_q;
                        rx_byte_valid_d = 1'b1;
                        bidx_d          = bidx_q + 2'd1;
                        case (bidx_q)
                            2'd0:    asm_d[7:0]   = shift_q;
                            2'd1:    asm_d[15:8]  = shift_q;
                            2'd2:    asm_d[23:16] = shift_q;
                            default: push         = 1'b1;
                        endcase
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= RX_IDLE;
            cnt_q           <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            bidx_q          <= '0;
            asm_q           <= '0;
            frame_err_q     <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_q           <= bit_d;
            shift_q         <= shift_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            bidx_q          <= bidx_d;
            asm_q           <= asm_d;
            frame_err_q     <= frame_err_d;
            overrun_q       <= overrun_d;
        end
    end

    assign fifo_pop = !fifo_empty && word_ready;

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (fifo_pop),
        .head_o      (word_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full_unused),
        .drop_o      (fifo_drop)
    );

    assign word_valid    = !fifo_empty;
    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign rx_busy       = (state_q != RX_IDLE);
    assign overrun       = overrun_q;
    assign frame_err     = frame_err_q;

endmodule
